// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmit port among N_REQ byte requesters.
// Grant edge -> one-cycle txclk/ack strobe -> wait for txready to drop (or TIMEOUT) -> idle.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               hz100,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [7:0]         txdata,
  output logic               txclk,
  input  logic               txready,
  output logic               busy,
  output logic [2:0]         grant_id
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       txdata_q, txdata_d;
  logic             txclk_q, txclk_d;
  logic             busy_q, busy_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [2:0]       gid_q, gid_d;

  logic             found_hi, found_lo;
  logic [2:0]       winner_hi, winner_lo, winner;
  logic [7:0]       sel_byte;

  // Search ptr..N_REQ-1 first; fall back to the lowest requester below ptr (wrap-around).
  always_comb begin
    found_hi  = 1'b0;
    found_lo  = 1'b0;
    winner_hi = '0;
    winner_lo = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (req[j] && !found_hi && (j >= int'(ptr_q))) begin
        found_hi  = 1'b1;
        winner_hi = 3'(j);
      end
      if (req[j] && !found_lo) begin
        found_lo  = 1'b1;
        winner_lo = 3'(j);
      end
    end
    winner = found_hi ? winner_hi : winner_lo;
  end

  always_comb begin
    sel_byte = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (winner == 3'(j)) begin
        sel_byte = req_data[8*j +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    txdata_d = txdata_q;
    gid_d    = gid_q;
    txclk_d  = 1'b0;
    ack_d    = '0;
    case (state_q)
      IDLE: begin
        if (txready && found_lo) begin
          state_d  = STROBE;
          txdata_d = sel_byte;
          gid_d    = winner;
          txclk_d  = 1'b1;
          ack_d    = N_REQ'(1) << winner;
          ptr_d    = (winner == 3'(N_REQ - 1)) ? 3'd0 : winner + 3'd1;
        end
      end
      STROBE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // A transmitter that never reports busy is abandoned after TIMEOUT+1 cycles.
        if (!txready || (cnt_q == CW'(TIMEOUT))) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      txdata_q <= 8'h00;
      txclk_q  <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
      gid_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      txdata_q <= txdata_d;
      txclk_q  <= txclk_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      gid_q    <= gid_d;
    end
  end

  assign ack      = ack_q;
  assign txdata   = txdata_q;
  assign txclk    = txclk_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, all checked cycle by
// cycle against a transaction-level reference (round-robin pick + grant/idle timing rules).
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic           hz100 = 1'b0;
  logic           reset = 1'b1;
  logic           txready = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   ack;
  logic [7:0]     txdata;
  logic           txclk;
  logic           busy;
  logic [2:0]     grant_id;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .hz100    (hz100),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .txdata   (txdata),
    .txclk    (txclk),
    .txready  (txready),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 hz100 = ~hz100;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int         ptr_m = 0;
  bit         idle_m = 1'b1;
  int         edge_n = 0;
  int         grant_edge = 0;
  logic       e_txclk = 1'b0;
  logic [N-1:0] e_ack = '0;
  logic       e_busy = 1'b0;
  logic [7:0] e_txdata = 8'h00;
  logic [2:0] e_gid = 3'd0;

  logic [16:0] obs, exp_v;
  assign obs   = {txclk, ack, busy, txdata, grant_id};
  assign exp_v = {e_txclk, e_ack, e_busy, e_txdata, e_gid};

  // stimulus helpers: UART busy emulation and requester release behaviour
  bit           uart_auto = 1'b0;
  int           uart_hold = 5;
  int           uart_cnt = 0;
  logic [N-1:0] persist = '0;
  logic [N-1:0] drop_pending = '0;

  task automatic tick();
    logic [N-1:0]   r;
    logic [8*N-1:0] d, sh;
    logic           rdy, rst;
    int             w;
    r = req; d = req_data; rdy = txready; rst = reset;
    @(posedge hz100);
    edge_n++;
    e_txclk = 1'b0;
    e_ack   = '0;
    if (rst) begin
      ptr_m = 0; idle_m = 1'b1; e_txdata = 8'h00; e_gid = 3'd0;
    end else if (idle_m) begin
      if (rdy && (r != '0)) begin
        w = -1;
        for (int i = 0; i < N; i++) begin
          if (w < 0 && (((r >> ((ptr_m + i) % N)) & 1) != 0)) w = (ptr_m + i) % N;
        end
        sh = d >> (8 * w);
        e_txclk = 1'b1; e_ack = N'(1) << w; e_txdata = sh[7:0]; e_gid = 3'(w);
        ptr_m = (w + 1) % N; idle_m = 1'b0; grant_edge = edge_n;
      end
    end else if (edge_n >= grant_edge + 2) begin
      if (!rdy || (edge_n == grant_edge + TO + 2)) idle_m = 1'b1;
    end
    e_busy = !idle_m;
    #1;
    // A transfer cut short by reset is still owed, so the requester keeps asking.
    if (rst) drop_pending = '0;
    for (int i = 0; i < N; i++) if (drop_pending[i] && !persist[i]) req[i] = 1'b0;
    drop_pending = ack;
    if (uart_auto) begin
      if (txclk) uart_cnt = uart_hold;
      txready = (uart_cnt == 0);
      if (uart_cnt > 0) uart_cnt--;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; uart_cnt = 0; persist = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'hF; txready = 1'b1; req_data = 32'h13121110;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if (obs !== 17'h0) begin
        miscompares++; $display("FAIL reset_hold cyc%0d: got %h want 00000", c, obs);
      end
    end
    reset = 1'b0; persist = 4'hF;
    tick();
    vectors++;
    if ({txclk, ack, grant_id, txdata} !== {1'b1, 4'b0001, 3'd0, 8'h10}) begin
      miscompares++; $display("FAIL reset_first_grant: got %b %b %0d %h want 1 0001 0 10", txclk, ack, grant_id, txdata);
    end
    vectors++;
    if (obs !== exp_v) begin
      miscompares++; $display("FAIL reset_model: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_single();
    int pulses = 0;
    do_reset();
    uart_auto = 1'b1; uart_hold = 5; txready = 1'b1;
    req_data = 32'h00410000; req = 4'b0100;
    for (int c = 0; c < 40; c++) begin
      tick();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL single_model edge%0d: got %h want %h", edge_n, obs, exp_v);
      end
      if (txclk === 1'b1) begin
        pulses++;
        vectors++;
        if ({txdata, ack, grant_id} !== {8'h41, 4'b0100, 3'd2}) begin
          miscompares++; $display("FAIL single_pulse: got %h %b %0d want 41 0100 2", txdata, ack, grant_id);
        end
      end
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++; $display("FAIL single_count: got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] order[8];
    logic [2:0] gids[6];
    int n = 0;
    do_reset();
    uart_auto = 1'b1; uart_hold = 2; txready = 1'b1;
    req_data = 32'h13121110; persist = 4'hF; req = 4'hF;
    for (int c = 0; c < 200 && n < 8; c++) begin
      tick();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL fair_model edge%0d: got %h want %h", edge_n, obs, exp_v);
      end
      if (txclk === 1'b1) begin order[n] = txdata; n++; end
    end
    vectors++;
    if (n !== 8) begin
      miscompares++; $display("FAIL fair_timeout: got %0d pulses want 8", n);
    end
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (order[i] !== 8'(8'h10 + (i % 4))) begin
        miscompares++; $display("FAIL fair_order[%0d]: got %h want %h", i, order[i], 8'(8'h10 + (i % 4)));
      end
    end
    do_reset();
    persist = 4'b0101; req = 4'b0101; n = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      tick();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL alt_model edge%0d: got %h want %h", edge_n, obs, exp_v);
      end
      if (txclk === 1'b1) begin gids[n] = grant_id; n++; end
    end
    vectors++;
    if (n !== 6) begin
      miscompares++; $display("FAIL alt_timeout: got %0d pulses want 6", n);
    end
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (gids[i] !== 3'((i % 2) * 2)) begin
        miscompares++; $display("FAIL alt_order[%0d]: got %0d want %0d", i, gids[i], (i % 2) * 2);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    uart_auto = 1'b0; txready = 1'b0; req_data = 32'h0000005A; req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      vectors++;
      if ({txclk, ack} !== 5'b0 || obs !== exp_v) begin
        miscompares++; $display("FAIL bp_hold edge%0d: got %h want %h", edge_n, obs, exp_v);
      end
    end
    txready = 1'b1;
    tick();
    vectors++;
    if ({txclk, ack, txdata} !== {1'b1, 4'b0001, 8'h5A}) begin
      miscompares++; $display("FAIL bp_grant: got %b %b %h want 1 0001 5a", txclk, ack, txdata);
    end
    tick();
    vectors++;
    if (txclk !== 1'b0 || obs !== exp_v) begin
      miscompares++; $display("FAIL bp_after: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_timeout();
    int last = -1;
    int pulses = 0;
    do_reset();
    uart_auto = 1'b0; txready = 1'b1; req_data = 32'h000000C3; persist = 4'b0001; req = 4'b0001;
    for (int c = 0; c < 80; c++) begin
      tick();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL to_model edge%0d: got %h want %h", edge_n, obs, exp_v);
      end
      if (txclk === 1'b1) begin
        pulses++;
        if (last >= 0) begin
          vectors++;
          if (edge_n - last !== TO + 3) begin
            miscompares++; $display("FAIL to_spacing: got %0d want %0d", edge_n - last, TO + 3);
          end
        end
        last = edge_n;
      end
    end
    vectors++;
    if (pulses < 4) begin
      miscompares++; $display("FAIL to_count: got %0d pulses want >=4", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int acks0 = 0, acks1 = 0;
    int first_gid = -1;
    do_reset();
    uart_auto = 1'b0; txready = 1'b1; req_data = 32'h0000A1A0; req = 4'b0011;
    tick();
    vectors++;
    if ({txclk, ack} !== {1'b1, 4'b0001}) begin
      miscompares++; $display("FAIL mid_strobe: got %b %b want 1 0001", txclk, ack);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (obs !== 17'h0) begin
      miscompares++; $display("FAIL mid_reset: got %h want 00000", obs);
    end
    reset = 1'b0; uart_auto = 1'b1; uart_hold = 3; uart_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL mid_model edge%0d: got %h want %h", edge_n, obs, exp_v);
      end
      if (txclk === 1'b1 && first_gid < 0) first_gid = int'(grant_id);
      if (ack[0] === 1'b1) acks0++;
      if (ack[1] === 1'b1) acks1++;
    end
    vectors++;
    if (first_gid !== 0) begin
      miscompares++; $display("FAIL mid_ptr: got first grant %0d want 0", first_gid);
    end
    vectors++;
    if (acks0 !== 1 || acks1 !== 1) begin
      miscompares++; $display("FAIL mid_acks: got %0d/%0d want 1/1", acks0, acks1);
    end
  endtask

  task automatic test_random();
    do_reset();
    uart_auto = 1'b0;
    for (int c = 0; c < 800; c++) begin
      txready = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            req_data[8*i +: 8] = 8'($urandom);
          end
        end else if (!drop_pending[i] && !ack[i] && $urandom_range(0, 49) == 0) begin
          req[i] = 1'b0;
        end
      end
      tick();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL rand_model edge%0d: got %h want %h", edge_n, obs, exp_v);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
